// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM state encoding and default sizing for spi_arbiter.
// Contents: state_t (IDLE, LAUNCH, BUSY, DONE), NREQ_DEF, DW_DEF.
package spi_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;
endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting after last_winner.
// Ports: req (request vector), last_winner (previous grant index),
//        winner (selected index), valid (any request present).
module rr_pick #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_winner,
  output logic [IW-1:0] winner,
  output logic          valid
);
  // Scan from the farthest candidate to the nearest so the nearest one after
  // last_winner overwrites the rest and wins.
  always_comb begin
    winner = '0;
    valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_winner) + k) % N]) begin
        winner = IW'((int'(last_winner) + k) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master among NREQ requesters.
// Ports: clk, rst (async, active-high); req/req_data from requesters;
//        gnt/done/rsp_data/err back to requesters; m_newd/m_din to the SPI
//        master, m_cs/m_dout from it.
// Build option: SPI_ARB_TIMEOUT_EN adds a LAUNCH/BUSY watchdog of TIMEOUT_CYC
// cycles that ends a stuck transfer with err and rsp_data=0.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW = DW_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rsp_data,
  output logic             err,
  output logic             m_newd,
  output logic [DW-1:0]    m_din,
  input  logic             m_cs,
  input  logic [DW-1:0]    m_dout
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state, state_n;
  logic [IW-1:0] last_winner, pick;
  logic pick_v, cs_q, cs_rise, to_hit, active;
  rr_pick #(.N(NREQ)) u_pick (
    .req(req),
    .last_winner(last_winner),
    .winner(pick),
    .valid(pick_v)
  );
  assign active = state == LAUNCH || state == BUSY;
  assign cs_rise = !cs_q && m_cs;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err_q;
  // Counter is held at zero in IDLE, so it starts from zero on LAUNCH entry.
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= active ? cnt + 1'b1 : (state == IDLE ? '0 : cnt);
  assign to_hit = active && cnt == CW'(TIMEOUT_CYC - 1);
  // to_hit only fires on the way into DONE, so err_q is high exactly in DONE.
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else err_q <= to_hit;
  assign err = err_q;
`else
  assign to_hit = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pick_v ? LAUNCH : IDLE;
      LAUNCH:  state_n = to_hit ? DONE : (!m_cs ? BUSY : LAUNCH);
      BUSY:    state_n = (to_hit || cs_rise) ? DONE : BUSY;
      default: state_n = IDLE;
    endcase
  end
  // last_winner doubles as the current grant index while a transfer is live.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_winner <= IW'(NREQ - 1);
      m_din <= '0;
      rsp_data <= '0;
      cs_q <= 1'b1;
    end else begin
      cs_q <= m_cs;
      if (state == IDLE && pick_v) begin
        last_winner <= pick;
        m_din <= req_data[int'(pick)*DW +: DW];
      end
      if (active && state_n == DONE) rsp_data <= to_hit ? '0 : m_dout;
    end
  assign gnt = state == IDLE ? '0 : NREQ'(1) << last_winner;
  assign done = state == DONE ? NREQ'(1) << last_winner : '0;
  assign m_newd = state == LAUNCH;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a loopback SPI master
// model (RX byte = TX byte ^ 8'hFF). Define SPI_ARB_TIMEOUT_EN to add the
// watchdog scenario.
module tb_spi_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  typedef struct {int idx; logic [7:0] tx; logic [7:0] rx; logic e;} exp_t;
  logic clk = 0, rst = 1, m_cs, stuck = 0;
  logic [NREQ-1:0] req, gnt, done;
  logic [NREQ*DW-1:0] req_data = {8'h81, 8'h0F, 8'h3C, 8'hA5};
  logic [DW-1:0] rsp_data, m_din, m_dout;
  logic err, m_newd, newd_q;
  int issued[NREQ] = '{default: 0};
  int served[NREQ] = '{default: 0};
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  spi_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .done(done), .rsp_data(rsp_data), .err(err), .m_newd(m_newd),
    .m_din(m_din), .m_cs(m_cs), .m_dout(m_dout)
  );
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < NREQ; i++) req[i] = issued[i] > served[i];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input int idx, input logic [7:0] tx, input logic [7:0] rx, input logic e);
    sb.push_back('{idx, tx, rx, e});
  endtask
  task automatic add(input int i, input int n);
    issued[i] = served[i] + n;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while ((req != 0 || gnt != 0 || sb.size() != 0) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("idle_within_budget", 32'(k < lim), 32'd1);
  endtask
  task automatic wait_busy();
    int k = 0;
    while (m_cs !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("cs_low_within_budget", 32'(k < 40), 32'd1);
    @(negedge clk);
  endtask
  initial begin
    m_cs = 1;
    m_dout = '0;
    forever begin
      @(negedge clk);
      if (m_newd && m_cs && !stuck) begin
        m_cs = 0;
        repeat (3) @(negedge clk);
        m_dout = m_din ^ 8'hFF;
        m_cs = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst) newd_q <= 1'b0;
    else begin
      if (m_newd && !newd_q) begin
        if (sb.size() == 0) chk("launch_expected", 32'd0, 32'd1);
        else begin
          chk("launch_din", 32'(m_din), 32'(sb[0].tx));
          chk("launch_gnt", 32'(gnt), 32'd1 << sb[0].idx);
        end
      end
      if (|done) begin
        if (sb.size() == 0) chk("done_expected", 32'(done), 32'd0);
        else begin
          chk("done_onehot", 32'(done), 32'd1 << sb[0].idx);
          chk("done_gnt", 32'(gnt), 32'd1 << sb[0].idx);
          chk("rsp_data", 32'(rsp_data), 32'(sb[0].rx));
          chk("err", 32'(err), 32'(sb[0].e));
          void'(sb.pop_front());
        end
        for (int i = 0; i < NREQ; i++) if (done[i]) served[i] <= served[i] + 1;
      end
      newd_q <= m_newd;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_newd", 32'(m_newd), 32'd0);
    chk("rst_din", 32'(m_din), 32'd0);
    chk("rst_rsp", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 0;
    @(negedge clk);
    push(0, 8'hA5, 8'h5A, 0);
    add(0, 1);
    @(negedge clk);
    chk("newd_latency", 32'(m_newd), 32'd1);
    wait_idle(60);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    push(0, 8'hA5, 8'h5A, 0);
    push(1, 8'h3C, 8'hC3, 0);
    push(2, 8'h0F, 8'hF0, 0);
    push(3, 8'h81, 8'h7E, 0);
    for (int i = 0; i < NREQ; i++) add(i, 1);
    wait_idle(200);
    push(0, 8'hA5, 8'h5A, 0);
    add(0, 1);
    wait_idle(60);
    push(2, 8'h0F, 8'hF0, 0);
    push(0, 8'hA5, 8'h5A, 0);
    add(0, 1);
    add(2, 1);
    wait_idle(120);
    push(3, 8'h81, 8'h7E, 0);
    push(0, 8'hA5, 8'h5A, 0);
    add(3, 1);
    add(0, 1);
    wait_idle(120);
    push(0, 8'hA5, 8'h5A, 0);
    push(0, 8'hA5, 8'h5A, 0);
    add(0, 2);
    wait_idle(120);
    push(1, 8'h3C, 8'hC3, 0);
    add(1, 1);
    wait_busy();
    issued[1] = served[1];
    wait_idle(60);
    repeat (4) @(negedge clk);
    chk("no_regrant_after_drop", 32'(gnt), 32'd0);
    push(2, 8'h0F, 8'hF0, 0);
    add(2, 1);
    wait_busy();
    rst = 1;
    #1;
    chk("rst_busy_newd", 32'(m_newd), 32'd0);
    chk("rst_busy_gnt", 32'(gnt), 32'd0);
    chk("rst_busy_done", 32'(done), 32'd0);
    chk("rst_busy_rsp", 32'(rsp_data), 32'd0);
    issued[2] = served[2];
    sb.delete();
    repeat (6) @(negedge clk);
    rst = 0;
    @(negedge clk);
    push(0, 8'hA5, 8'h5A, 0);
    push(2, 8'h0F, 8'hF0, 0);
    add(2, 1);
    add(0, 1);
    wait_idle(120);
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int k = 0;
      stuck = 1;
      push(1, 8'h3C, 8'h00, 1);
      add(1, 1);
      while (!m_newd && k < 10) begin
        @(negedge clk);
        k++;
      end
      k = 0;
      while (done == 0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("timeout_latency", 32'(k), 32'd16);
      wait_idle(60);
      stuck = 0;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one SPI master.
REQ-002 Parameter DW, default 8, transfer data width.
REQ-003 Parameter TIMEOUT_CYC, default 255, watchdog limit in clk cycles (used only with the timeout macro).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester transfer request, level, held until done.
REQ-007 req_data  input  NREQ*DW  flattened TX bytes, requester i at bits [i*DW +: DW].
REQ-008 gnt  output  NREQ  one-hot grant, high from launch through completion.
REQ-009 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 rsp_data  output  DW  RX byte of the last completed transfer, valid when any done is high.
REQ-011 err  output  1  timeout flag, pulses with done.
REQ-012 m_newd  output  1  start strobe to the SPI master.
REQ-013 m_din  output  DW  TX byte to the SPI master.
REQ-014 m_cs  input  1  SPI master chip select, active-low; low means a transfer is in progress.
REQ-015 m_dout  input  DW  RX byte from the SPI master.

Function
REQ-016 FSM states: IDLE, LAUNCH, BUSY, DONE.
REQ-017 IDLE: if any req is high, select a winner round-robin, searching upward from last_winner+1 with wrap at NREQ-1 -> 0, and go to LAUNCH next cycle.
REQ-018 On entry to LAUNCH, drive gnt=onehot(winner), m_newd=1, m_din=req_data[winner], and set last_winner=winner.
REQ-019 m_din is registered and holds stable from LAUNCH through DONE.
REQ-020 LAUNCH: when m_cs is sampled 0, drive m_newd=0 and go to BUSY.
REQ-021 BUSY: detect the m_cs rising edge (registered cs_q=0, m_cs=1), capture rsp_data<=m_dout, and go to DONE.
REQ-022 DONE lasts exactly one cycle: done[winner]=1, then gnt=0, then return to IDLE.
REQ-023 Minimum gap between done and the next m_newd is 1 cycle (the IDLE arbitration cycle).
REQ-024 A req dropped mid-transfer does not abort the transfer; done still pulses.
REQ-025 req for the current winner still high in IDLE after done is treated as a new request, subject to round-robin order.
REQ-026 A new req arriving during a transfer waits; requests are never lost or reordered against the round-robin order.
REQ-027 With a single active requester, back-to-back transfers are serviced to it without starvation.
REQ-028 m_cs held high in LAUNCH keeps m_newd asserted indefinitely unless the timeout macro is defined.

Reset
REQ-029 rst asserted: state=IDLE, gnt=0, done=0, err=0, m_newd=0, m_din=0, rsp_data=0, cs_q=1, last_winner=NREQ-1, so requester 0 is searched first.
REQ-030 rst mid-transfer deasserts m_newd and gnt immediately (asynchronously); the in-flight transfer gets no done pulse.

Configuration
REQ-031 Macro SPI_ARB_TIMEOUT_EN defined: a counter clears on entry to LAUNCH and counts in LAUNCH and BUSY.
REQ-032 With SPI_ARB_TIMEOUT_EN, reaching TIMEOUT_CYC forces m_newd=0, rsp_data=0, err=1, and a DONE cycle with done[winner]=1.
REQ-033 Without SPI_ARB_TIMEOUT_EN, no counter is built and err is tied 0.

Structure
REQ-034 Package spi_arb_pkg holds the FSM state enum and the default NREQ/DW constants.
REQ-035 Sub-module rr_pick holds the combinational round-robin winner search, with inputs req and last_winner and outputs winner and valid.

Verification
REQ-036 req=0001, req_data[0]=8'hA5, master loopback -> m_newd 1 cycle after req, m_din=A5, done[0] pulse after cs rises, rsp_data=m_dout.
REQ-037 req=1111 held for 4 transfers -> grant order 0,1,2,3; each done is exactly 1 cycle; gnt is always one-hot.
REQ-038 req=0101 with last_winner=0 -> next grant 2, then 0; wrap from 3 to 0 checked.
REQ-039 Drop req[1] while BUSY -> transfer completes, done[1] pulses, no second grant to 1.
REQ-040 Assert rst while BUSY -> m_newd, gnt, done, rsp_data all 0 in the same cycle; after release req[0] is served first.
REQ-041 With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16 and m_cs stuck high -> at cycle 16 of LAUNCH, err=1 with done pulse, rsp_data=0, FSM back in IDLE.
